// File: rtl/ifu_pkg.sv
// Shared widths, reset vector and encodings for the instruction fetch unit.
package ifu_pkg;
  localparam int          IFU_XLEN     = 64;
  localparam int          IFU_ILEN     = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
module ifu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic                    do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : AW'(p + AW'(1));
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= inc(wptr);
      end
      if (do_pop) rptr <= inc(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) (push && !clr) |-> !full);
endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: PC, credit-limited request issue, response tagging, redirect flush.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int               XLEN     = IFU_XLEN,
  parameter int               ILEN     = IFU_ILEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IFU_RESET_PC),
  parameter int               DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  input  logic            rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            out_err
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          EW      = XLEN + ILEN + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc, mis_pc, tag_pc;
  logic [CW-1:0]   inflight, drop, fifo_count, tag_count;
  logic [CW:0]     credit_used;
  logic            misalign_pending, halt, run;
  logic            req_fire, rsp_keep, mis_push, q_push, q_pop, q_empty, q_full;
  logic            tag_empty, tag_full;
  logic [EW-1:0]   q_wdata, q_rdata;

  // run holds off the first request until the cycle after reset release.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign req_valid   = run && !redirect_valid && !misalign_pending && !halt &&
                       (credit_used < DEPTH_C);
  assign req_addr    = fetch_pc;
  assign req_fire    = req_valid && req_ready;

  assign rsp_keep = rsp_valid && (drop == '0) && !redirect_valid;
  assign mis_push = misalign_pending && (drop == '0) && !redirect_valid;
  assign q_push   = rsp_keep || mis_push;
  assign q_wdata  = mis_push ? {mis_pc, ILEN'(IFU_NOP), 1'b1}
                             : {tag_pc, rsp_data, rsp_err};

  assign out_valid = !q_empty;
  assign q_pop     = out_valid && out_ready && !redirect_valid;
  assign {out_pc, out_inst, out_err} = out_valid ? q_rdata : '0;

  // Tags pop on every response, dropped or kept, so they stay aligned with memory order.
  ifu_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tagq (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_valid),
    .rdata (tag_pc),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

  ifu_fifo #(.W(EW), .DEPTH(DEPTH)) u_instq (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect_valid),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .count (fifo_count),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      mis_pc           <= '0;
      inflight         <= '0;
      drop             <= '0;
      misalign_pending <= 1'b0;
      halt             <= 1'b0;
      run              <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight + CW'(req_fire) - CW'(rsp_valid);
      if (redirect_valid) begin
        fetch_pc         <= {redirect_pc[XLEN-1:2], 2'b00};
        mis_pc           <= redirect_pc;
        drop             <= inflight - CW'(rsp_valid);
        misalign_pending <= (redirect_pc[1:0] != 2'b00);
        halt             <= 1'b0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_valid && (drop != '0)) drop <= drop - CW'(1);
        // The fault entry is emitted once; fetch then waits for the core to redirect.
        if (mis_push) begin
          misalign_pending <= 1'b0;
          halt             <= 1'b1;
        end
      end
    end
  end

  a_tag_sync:  assert property (@(posedge clk) disable iff (!rst) tag_count == inflight);
  a_rsp_owed:  assert property (@(posedge clk) disable iff (!rst) rsp_valid |-> !tag_empty);
  a_tag_room:  assert property (@(posedge clk) disable iff (!rst) req_fire |-> !tag_full);
  a_q_room:    assert property (@(posedge clk) disable iff (!rst) (q_push && !q_pop) |-> !q_full);
endmodule
